// File: rtl/nf10_router_pkg.sv
// -----------------------------------------------------------------------------
// nf10_router_pkg
// Shared definitions for the router IPv4 checksum front-end: bit offsets of the
// 16-bit IPv4 header words inside a 256-bit beat (byte 0 at [255:248], 14-byte
// Ethernet header first), the TTL pre-decrement constant, the partial-sum width,
// the FSM state types, and the beat-0 partial-sum helper.
// -----------------------------------------------------------------------------
package nf10_router_pkg;

   localparam int          SUM_W   = 20;
   localparam int          RES_W   = SUM_W + 16;
   localparam logic [15:0] TTL_DEC = 16'h0100;

   // IPv4 header words 0..8 live in beat 0, word 9 (dst IP low) in beat 1.
   // Word 5 (header checksum, [63:48]) is deliberately absent.
   localparam int IP_W0_LSB = 128;
   localparam int IP_W1_LSB = 112;
   localparam int IP_W2_LSB = 96;
   localparam int IP_W3_LSB = 80;
   localparam int IP_W4_LSB = 64;
   localparam int IP_W6_LSB = 32;
   localparam int IP_W7_LSB = 16;
   localparam int IP_W8_LSB = 0;
   localparam int IP_W9_LSB = 240;

   typedef enum logic [1:0] {
      IN_HDR0 = 2'd0,
      IN_HDR1 = 2'd1,
      IN_BODY = 2'd2
   } in_state_t;

   typedef enum logic {
      OUT_FIRST = 1'b0,
      OUT_BODY  = 1'b1
   } out_state_t;

   // Partial sum of the beat-0 header words. Subtracting 0x0100 from the
   // TTL/protocol word decrements TTL mod 256 without touching the protocol
   // byte or any neighbouring word.
   function automatic logic [SUM_W-1:0] beat0_sum(input logic [255:0] d);
      logic [15:0] w4;
      w4 = d[IP_W4_LSB +: 16] - TTL_DEC;
      return SUM_W'(d[IP_W0_LSB +: 16]) + SUM_W'(d[IP_W1_LSB +: 16]) +
             SUM_W'(d[IP_W2_LSB +: 16]) + SUM_W'(d[IP_W3_LSB +: 16]) +
             SUM_W'(w4)                 + SUM_W'(d[IP_W6_LSB +: 16]) +
             SUM_W'(d[IP_W7_LSB +: 16]) + SUM_W'(d[IP_W8_LSB +: 16]);
   endfunction

endpackage

// File: rtl/fallthrough_small_fifo.sv
// -----------------------------------------------------------------------------
// fallthrough_small_fifo
// Small synchronous FIFO whose head entry is visible on o_dout while not empty
// (no read latency). Depth is 2**MAX_DEPTH_BITS.
// Ports:
//   i_clk, i_rst      clock, asynchronous active-high reset (empties FIFO)
//   i_din, i_wr_en    write data / strobe (ignored when full)
//   i_rd_en           pop the head entry (ignored when empty)
//   o_dout            head entry
//   o_nearly_full     at most one free slot left
//   o_empty           no entries
// -----------------------------------------------------------------------------
module fallthrough_small_fifo #(
   parameter int WIDTH          = 72,
   parameter int MAX_DEPTH_BITS = 2
) (
   input  logic             i_clk,
   input  logic             i_rst,
   input  logic [WIDTH-1:0] i_din,
   input  logic             i_wr_en,
   input  logic             i_rd_en,
   output logic [WIDTH-1:0] o_dout,
   output logic             o_nearly_full,
   output logic             o_empty
);

   localparam int DEPTH = 1 << MAX_DEPTH_BITS;

   logic [WIDTH-1:0]          r_mem [DEPTH];
   logic [MAX_DEPTH_BITS-1:0] r_wr_ptr;
   logic [MAX_DEPTH_BITS-1:0] r_rd_ptr;
   logic [MAX_DEPTH_BITS:0]   r_count;
   logic                      w_wr;
   logic                      w_rd;

   assign o_empty       = (r_count == '0);
   assign o_nearly_full = (r_count >= (MAX_DEPTH_BITS+1)'(DEPTH - 1));
   assign o_dout        = r_mem[r_rd_ptr];

   assign w_wr = i_wr_en & (r_count != (MAX_DEPTH_BITS+1)'(DEPTH));
   assign w_rd = i_rd_en & !o_empty;

   always_ff @(posedge i_clk) begin
      if (w_wr) begin
         r_mem[r_wr_ptr] <= i_din;
      end
   end

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
      end else begin
         if (w_wr) begin
            r_wr_ptr <= r_wr_ptr + 1'b1;
         end
         if (w_rd) begin
            r_rd_ptr <= r_rd_ptr + 1'b1;
         end
         case ({w_wr, w_rd})
            2'b10:   r_count <= r_count + 1'b1;
            2'b01:   r_count <= r_count - 1'b1;
            default: r_count <= r_count;
         endcase
      end
   end

endmodule

// File: rtl/ip_checksum_calc.sv
// -----------------------------------------------------------------------------
// ip_checksum_calc
// Pass-through AXI4-Stream stage that computes, per packet, the 20-bit partial
// one's-complement sum of the IPv4 header (TTL pre-decremented, checksum word
// excluded, no end-around carry) and the low 16 bits of the destination IP.
// Both are presented on checksum_out / ip_addr_out starting the cycle after
// the packet's first output beat is accepted, and held until the next packet.
// Ports:
//   AXI_ACLK, AXI_RESET          clock, asynchronous active-high reset
//   S_AXIS_*                     input stream (TREADY is an output)
//   M_AXIS_*                     output stream, bit-identical to input
//   checksum_out                 partial header sum, zero-extended to 32 bits
//   ip_addr_out                  destination IP [15:0] (0 for 1-beat packets)
//   pkt_count                    packets released on M_AXIS, wraps at 2^32
//
// Input FSM
//   state   | meaning
//   IN_HDR0 | next accepted beat is beat 0 of a packet
//   IN_HDR1 | beat 0 latched, waiting for beat 1 (dst IP low, final sum)
//   IN_BODY | header done, forwarding until TLAST
// Output FSM
//   state     | meaning
//   OUT_FIRST | data FIFO head is a first beat; needs a result entry to go
//   OUT_BODY  | data FIFO head is a continuation beat
// -----------------------------------------------------------------------------
module ip_checksum_calc #(
   parameter int C_M_AXIS_DATA_WIDTH  = 256,
   parameter int C_S_AXIS_DATA_WIDTH  = 256,
   parameter int C_M_AXIS_TUSER_WIDTH = 128,
   parameter int C_S_AXIS_TUSER_WIDTH = 128
) (
   input  logic                              AXI_ACLK,
   input  logic                              AXI_RESET,
   input  logic [C_S_AXIS_DATA_WIDTH-1:0]    S_AXIS_TDATA,
   input  logic [C_S_AXIS_DATA_WIDTH/8-1:0]  S_AXIS_TSTRB,
   input  logic [C_S_AXIS_TUSER_WIDTH-1:0]   S_AXIS_TUSER,
   input  logic                              S_AXIS_TVALID,
   input  logic                              S_AXIS_TLAST,
   output logic                              S_AXIS_TREADY,
   output logic [C_M_AXIS_DATA_WIDTH-1:0]    M_AXIS_TDATA,
   output logic [C_M_AXIS_DATA_WIDTH/8-1:0]  M_AXIS_TSTRB,
   output logic [C_M_AXIS_TUSER_WIDTH-1:0]   M_AXIS_TUSER,
   output logic                              M_AXIS_TVALID,
   output logic                              M_AXIS_TLAST,
   input  logic                              M_AXIS_TREADY,
   output logic [31:0]                       checksum_out,
   output logic [15:0]                       ip_addr_out,
   output logic [31:0]                       pkt_count
);

   import nf10_router_pkg::*;

   localparam int DW = C_S_AXIS_DATA_WIDTH;
   localparam int UW = C_S_AXIS_TUSER_WIDTH;
   localparam int SW = C_S_AXIS_DATA_WIDTH / 8;
   localparam int FW = DW + UW + SW + 1;

   in_state_t         r_in_state, w_in_next;
   out_state_t        r_out_state, w_out_next;

   logic [SUM_W-1:0]  r_sum;
   logic [SUM_W-1:0]  w_b0_sum;
   logic [15:0]       w_w9;
   logic              w_sum_latch;
   logic              w_res_push;
   logic [RES_W-1:0]  w_res_din;
   logic              w_res_pop;
   logic [RES_W-1:0]  w_res_dout;
   logic              w_res_nf;
   logic              w_res_empty;

   logic [FW-1:0]     w_data_din;
   logic [FW-1:0]     w_data_dout;
   logic              w_data_nf;
   logic              w_data_empty;
   logic              w_dout_last;

   logic              w_in_hs;
   logic              w_out_hs;

   logic [SUM_W-1:0]  r_checksum;
   logic [15:0]       r_ip_addr;
   logic [31:0]       r_pkt_count;

   // ---------------------------------------------------------------- input side
   assign S_AXIS_TREADY = !w_data_nf & !w_res_nf;
   assign w_in_hs       = S_AXIS_TVALID & S_AXIS_TREADY;
   assign w_b0_sum      = beat0_sum(S_AXIS_TDATA);
   assign w_w9          = S_AXIS_TDATA[IP_W9_LSB +: 16];
   assign w_data_din    = {S_AXIS_TLAST, S_AXIS_TUSER, S_AXIS_TSTRB, S_AXIS_TDATA};

   always_ff @(posedge AXI_ACLK or posedge AXI_RESET) begin
      if (AXI_RESET) begin
         r_in_state <= IN_HDR0;
         r_sum      <= '0;
      end else begin
         r_in_state <= w_in_next;
         if (w_sum_latch) begin
            r_sum <= w_b0_sum;
         end
      end
   end

   always_comb begin
      w_in_next   = r_in_state;
      w_sum_latch = 1'b0;
      w_res_push  = 1'b0;
      w_res_din   = '0;
      case (r_in_state)
         IN_HDR0: begin
            if (w_in_hs) begin
               if (S_AXIS_TLAST) begin
                  // Single-beat packet: beat 1 never comes, so no dst IP.
                  w_res_push = 1'b1;
                  w_res_din  = {w_b0_sum, 16'h0000};
               end else begin
                  w_sum_latch = 1'b1;
                  w_in_next   = IN_HDR1;
               end
            end
         end
         IN_HDR1: begin
            if (w_in_hs) begin
               w_res_push = 1'b1;
               w_res_din  = {r_sum + SUM_W'(w_w9), w_w9};
               w_in_next  = S_AXIS_TLAST ? IN_HDR0 : IN_BODY;
            end
         end
         IN_BODY: begin
            if (w_in_hs && S_AXIS_TLAST) begin
               w_in_next = IN_HDR0;
            end
         end
         default: w_in_next = IN_HDR0;
      endcase
   end

   // -------------------------------------------------------------------- FIFOs
   fallthrough_small_fifo #(
      .WIDTH          (FW),
      .MAX_DEPTH_BITS (2)
   ) u_data_fifo (
      .i_clk         (AXI_ACLK),
      .i_rst         (AXI_RESET),
      .i_din         (w_data_din),
      .i_wr_en       (w_in_hs),
      .i_rd_en       (w_out_hs),
      .o_dout        (w_data_dout),
      .o_nearly_full (w_data_nf),
      .o_empty       (w_data_empty)
   );

   fallthrough_small_fifo #(
      .WIDTH          (RES_W),
      .MAX_DEPTH_BITS (2)
   ) u_result_fifo (
      .i_clk         (AXI_ACLK),
      .i_rst         (AXI_RESET),
      .i_din         (w_res_din),
      .i_wr_en       (w_res_push),
      .i_rd_en       (w_res_pop),
      .o_dout        (w_res_dout),
      .o_nearly_full (w_res_nf),
      .o_empty       (w_res_empty)
   );

   // --------------------------------------------------------------- output side
   assign M_AXIS_TDATA  = w_data_dout[DW-1:0];
   assign M_AXIS_TSTRB  = w_data_dout[DW+SW-1:DW];
   assign M_AXIS_TUSER  = w_data_dout[DW+SW+UW-1:DW+SW];
   assign w_dout_last   = w_data_dout[FW-1];
   assign M_AXIS_TLAST  = w_dout_last;

   // A first beat may only leave once its header result exists; this is what
   // holds beat 0 back until beat 1 has been accepted.
   assign M_AXIS_TVALID = !w_data_empty & ((r_out_state != OUT_FIRST) | !w_res_empty);
   assign w_out_hs      = M_AXIS_TVALID & M_AXIS_TREADY;

   always_ff @(posedge AXI_ACLK or posedge AXI_RESET) begin
      if (AXI_RESET) begin
         r_out_state <= OUT_FIRST;
      end else begin
         r_out_state <= w_out_next;
      end
   end

   always_comb begin
      w_out_next = r_out_state;
      w_res_pop  = 1'b0;
      if (w_out_hs) begin
         w_res_pop  = (r_out_state == OUT_FIRST);
         w_out_next = w_dout_last ? OUT_FIRST : OUT_BODY;
      end
   end

   always_ff @(posedge AXI_ACLK or posedge AXI_RESET) begin
      if (AXI_RESET) begin
         r_checksum  <= '0;
         r_ip_addr   <= '0;
         r_pkt_count <= '0;
      end else if (w_res_pop) begin
         r_checksum  <= w_res_dout[RES_W-1:16];
         r_ip_addr   <= w_res_dout[15:0];
         r_pkt_count <= r_pkt_count + 32'd1;
      end
   end

   assign checksum_out = {{(32-SUM_W){1'b0}}, r_checksum};
   assign ip_addr_out  = r_ip_addr;
   assign pkt_count    = r_pkt_count;

endmodule

// File: tb/tb_ip_checksum_calc.sv
// -----------------------------------------------------------------------------
// tb_ip_checksum_calc
// Directed-vector bench for ip_checksum_calc. Packets are built from a byte
// array holding a 10-word IPv4 header at byte offset 14; the expected sum is
// computed from those header words by plain integer arithmetic. A negedge
// compare process checks every output beat and the per-packet side outputs.
// -----------------------------------------------------------------------------
module tb_ip_checksum_calc;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic [255:0]  S_TDATA = '0;
   logic [31:0]   S_TSTRB = '0;
   logic [127:0]  S_TUSER = '0;
   logic          S_TVALID = 1'b0;
   logic          S_TLAST = 1'b0;
   logic          S_TREADY;
   logic [255:0]  M_TDATA;
   logic [31:0]   M_TSTRB;
   logic [127:0]  M_TUSER;
   logic          M_TVALID;
   logic          M_TLAST;
   logic          M_TREADY = 1'b1;
   logic [31:0]   checksum_out;
   logic [15:0]   ip_addr_out;
   logic [31:0]   pkt_count;

   always #5 clk = ~clk;

   ip_checksum_calc dut (
      .AXI_ACLK      (clk),
      .AXI_RESET     (rst),
      .S_AXIS_TDATA  (S_TDATA),
      .S_AXIS_TSTRB  (S_TSTRB),
      .S_AXIS_TUSER  (S_TUSER),
      .S_AXIS_TVALID (S_TVALID),
      .S_AXIS_TLAST  (S_TLAST),
      .S_AXIS_TREADY (S_TREADY),
      .M_AXIS_TDATA  (M_TDATA),
      .M_AXIS_TSTRB  (M_TSTRB),
      .M_AXIS_TUSER  (M_TUSER),
      .M_AXIS_TVALID (M_TVALID),
      .M_AXIS_TLAST  (M_TLAST),
      .M_AXIS_TREADY (M_TREADY),
      .checksum_out  (checksum_out),
      .ip_addr_out   (ip_addr_out),
      .pkt_count     (pkt_count)
   );

   typedef struct {
      logic [255:0] data;
      logic [127:0] user;
      logic [31:0]  strb;
      logic         last;
      logic         first;
      logic [31:0]  cs;
      logic [15:0]  ip;
   } beat_t;

   int          errors = 0;
   int          checks = 0;
   bit          chk_en = 1'b0;
   logic [15:0] hdr [10];
   logic [7:0]  pbytes [128];
   beat_t       q [$];
   logic [31:0] exp_cs  = '0;
   logic [15:0] exp_ip  = '0;
   logic [31:0] exp_cnt = '0;
   bit          saw_low;

   localparam logic [159:0] H_REF  = 160'h4500_0073_0000_4000_4011_b861_c0a8_0001_c0a8_00c7;
   localparam logic [159:0] H_TTL0 = 160'h4500_0073_0000_4000_0011_b861_c0a8_0001_c0a8_00c7;
   localparam logic [159:0] H_ONES = {10{16'hFFFF}};
   localparam logic [159:0] H_B    = 160'h4500_0054_1c46_4000_0106_0000_0a00_0001_0a00_0002;
   localparam logic [159:0] H_C    = 160'h4500_05dc_abcd_0000_8011_1234_ac10_fe01_ac10_0a0b;

   task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic stop_now(input string why);
      errors++;
      $display("FAIL %s: bound expired", why);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $fatal(1, "aborted");
   endtask

   // Sum of header words 0..9 except the checksum word, with TTL - 1 (mod 256);
   // word 9 is only reachable when the packet has a second beat.
   function automatic logic [19:0] model_sum(input bit single);
      int s;
      int ttl;
      s = 0;
      for (int i = 0; i < 10; i++) begin
         if (i == 5) continue;
         if (i == 9 && single) continue;
         if (i == 4) begin
            ttl = (int'(hdr[4][15:8]) + 255) % 256;
            s  += ttl * 256 + int'(hdr[4][7:0]);
         end else begin
            s += int'(hdr[i]);
         end
      end
      return s[19:0];
   endfunction

   task automatic set_hdr(input logic [159:0] h, input int seed);
      for (int i = 0; i < 10; i++) hdr[i] = h[159-16*i -: 16];
      for (int k = 0; k < 128; k++) pbytes[k] = 8'(k * 7 + seed);
      for (int i = 0; i < 10; i++) begin
         pbytes[14+2*i] = hdr[i][15:8];
         pbytes[15+2*i] = hdr[i][7:0];
      end
   endtask

   // Sends beats [0, stop_at) of an nbeats packet. gap idles before beat 1.
   // lat enables the first-beat hold/latency checks (only meaningful from idle).
   task automatic send_pkt(input int nbeats, input int stop_at, input int gap, input bit lat);
      beat_t       e;
      logic [19:0] ecs;
      int          wc;
      ecs = model_sum(nbeats == 1);
      for (int b = 0; b < stop_at; b++) begin
         for (int k = 0; k < 32; k++) e.data[255-8*k -: 8] = pbytes[32*b+k];
         e.user  = {$urandom, $urandom, $urandom, $urandom};
         e.strb  = (b == nbeats-1) ? 32'hFFFF_0000 : 32'hFFFF_FFFF;
         e.last  = (b == nbeats-1);
         e.first = (b == 0);
         e.cs    = {12'h000, ecs};
         e.ip    = (nbeats == 1) ? 16'h0000 : hdr[9];
         if (b == 1 && gap > 0) begin
            S_TVALID = 1'b0;
            repeat (gap) begin
               @(negedge clk);
               if (lat) chk("gap_tvalid_low", M_TVALID, 0);
               @(posedge clk);
               #1;
            end
         end
         S_TDATA  = e.data;
         S_TUSER  = e.user;
         S_TSTRB  = e.strb;
         S_TLAST  = e.last;
         S_TVALID = 1'b1;
         @(negedge clk);
         if (lat && b == 1) chk("beat0_held_tvalid", M_TVALID, 0);
         if (lat && b == 2) chk("beat0_latency_tvalid", M_TVALID, 1);
         wc = 0;
         while (!S_TREADY) begin
            wc++;
            if (wc > 500) stop_now("s_tready_timeout");
            @(negedge clk);
         end
         @(posedge clk);
         q.push_back(e);
         #1;
      end
      S_TVALID = 1'b0;
      if (lat && nbeats == 1) begin
         @(negedge clk);
         chk("single_latency_tvalid", M_TVALID, 1);
      end
   endtask

   task automatic drain();
      int n;
      n = 0;
      while (q.size() > 0 && n < 300) begin
         @(posedge clk);
         n++;
      end
      chk("drain_queue_empty", q.size(), 0);
      repeat (2) @(posedge clk);
      #1;
   endtask

   // Compare process: side outputs every cycle, stream beats on each transfer.
   always @(negedge clk) begin : compare
      beat_t e;
      if (chk_en) begin
         chk("checksum_out", checksum_out, exp_cs);
         chk("ip_addr_out", ip_addr_out, exp_ip);
         chk("pkt_count", pkt_count, exp_cnt);
         if (M_TVALID && M_TREADY) begin
            if (q.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL unexpected_beat: got output beat, expected none");
            end else begin
               e = q.pop_front();
               chk("m_tdata", M_TDATA, e.data);
               chk("m_tuser", M_TUSER, e.user);
               chk("m_tstrb", M_TSTRB, e.strb);
               chk("m_tlast", M_TLAST, e.last);
               if (e.first) begin
                  exp_cs  = e.cs;
                  exp_ip  = e.ip;
                  exp_cnt = exp_cnt + 32'd1;
               end
            end
         end
      end
   end

   initial begin : watchdog
      #200000;
      stop_now("global_timeout");
   end

   initial begin : main
      logic [16:0] t;
      logic [15:0] fold;

      repeat (3) @(posedge clk);
      #1;
      chk("rst_m_tvalid", M_TVALID, 0);
      chk("rst_s_tready", S_TREADY, 1);
      chk("rst_checksum", checksum_out, 0);
      chk("rst_ip_addr", ip_addr_out, 0);
      chk("rst_pkt_count", pkt_count, 0);
      rst = 1'b0;
      @(posedge clk);
      #1;
      chk_en = 1'b1;

      // single-beat packet
      set_hdr(H_REF, 1);
      send_pkt(1, 1, 0, 1);
      drain();
      chk("single_checksum_lit", checksum_out, 32'h0002_45D5);
      chk("single_ip_lit", ip_addr_out, 16'h0000);
      chk("single_pkt_count_lit", pkt_count, 32'd1);

      // reference 3-beat packet
      set_hdr(H_REF, 2);
      send_pkt(3, 3, 0, 1);
      drain();
      chk("ref_checksum_lit", checksum_out, 32'h0002_469C);
      chk("ref_ip_lit", ip_addr_out, 16'h00C7);
      t    = {1'b0, checksum_out[15:0]} + 17'(checksum_out[19:16]);
      fold = ~(t[15:0] + 16'(t[16]));
      chk("ref_fold_lit", fold, 16'hB961);

      // TTL = 0 wraps to 0xFF without borrowing into neighbours
      set_hdr(H_TTL0, 3);
      send_pkt(3, 3, 0, 0);
      drain();
      chk("ttl0_checksum_lit", checksum_out, 32'h0003_069C);

      // back-to-back packets against a 20-cycle output stall
      M_TREADY = 1'b0;
      saw_low  = 1'b0;
      fork
         begin
            set_hdr(H_ONES, 4);
            send_pkt(3, 3, 0, 0);
            set_hdr(H_B, 5);
            send_pkt(1, 1, 0, 0);
            set_hdr(H_C, 6);
            send_pkt(4, 4, 0, 0);
            set_hdr(H_REF, 7);
            send_pkt(2, 2, 0, 0);
         end
         begin
            repeat (20) begin
               @(negedge clk);
               if (!S_TREADY) saw_low = 1'b1;
            end
            @(posedge clk);
            #1;
            M_TREADY = 1'b1;
         end
      join
      drain();
      chk("stall_s_tready_dropped", saw_low, 1);
      chk("stall_pkt_count_lit", pkt_count, 32'd7);

      // 5-cycle gap between beats 0 and 1
      set_hdr(H_C, 8);
      send_pkt(3, 3, 5, 1);
      drain();

      // asynchronous reset in the middle of a packet
      set_hdr(H_B, 9);
      send_pkt(3, 2, 0, 0);
      chk_en = 1'b0;
      #2;
      rst = 1'b1;
      #1;
      chk("midrst_m_tvalid", M_TVALID, 0);
      chk("midrst_s_tready", S_TREADY, 1);
      chk("midrst_checksum", checksum_out, 0);
      chk("midrst_ip_addr", ip_addr_out, 0);
      chk("midrst_pkt_count", pkt_count, 0);
      q.delete();
      exp_cs  = '0;
      exp_ip  = '0;
      exp_cnt = '0;
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b0;
      @(posedge clk);
      #1;
      chk_en = 1'b1;
      set_hdr(H_REF, 10);
      send_pkt(3, 3, 0, 1);
      drain();
      chk("post_rst_checksum_lit", checksum_out, 32'h0002_469C);
      chk("post_rst_ip_lit", ip_addr_out, 16'h00C7);
      chk("post_rst_pkt_count_lit", pkt_count, 32'd1);

      chk_en = 1'b0;
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
